ftdi_receiver: RTL and testbench

UART receive path for the FTDI serial link, the counterpart of the FTDI transmit block. Deserialises 8N1 frames arriving on FTDI_TX (LSB first, idle high) into bytes. A one-byte holding register presents each byte to the core logic with a valid/ack handshake, and FTDI_RTS signals the host when that register can accept data. Uses 16x oversampling from a phase-accumulator tick generator built the same way as the transmitter's baud generator.

---
 rtl/ftdi_receiver.sv | 133 +++++++++++++
 tb/tb_ftdi_receiver.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ftdi_receiver.sv
// UART 8N1 receive path for the FTDI link: 16x oversampled deserialiser
// feeding a one-byte holding register with a valid/ack handshake.
module ftdi_receiver #(
  parameter int unsigned FREQUENCY         = 50_000_000,
  parameter int unsigned BAUD_RATE         = 115200,
  parameter int unsigned OVERSAMPLE        = 16,
  parameter int unsigned BAUD_RG_WIDTH     = 32,
  parameter logic [63:0] BAUD_INCREMENT_BY =
    ((64'(BAUD_RATE) * 64'(OVERSAMPLE)) << BAUD_RG_WIDTH) / 64'(FREQUENCY)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       FTDI_TX,
  output logic       FTDI_RTS,
  output logic [7:0] data,
  output logic       data_valid,
  input  logic       data_ack,
  output logic       framing_error,
  output logic       overrun,
  output logic [1:0] state_test
);

  localparam int unsigned W = BAUD_RG_WIDTH;
  localparam logic [W:0] INC = BAUD_INCREMENT_BY[W:0];

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } state_t;

  state_t     state;
  logic       sync1;
  logic       rx_s;
  logic       rx_prev;
  logic [W:0] acc;
  logic       tick;
  logic [3:0] tcnt;
  logic [2:0] bcnt;
  logic [7:0] shreg;
  logic       half_bit;
  logic       full_bit;

  assign tick       = acc[W];
  assign state_test = state;

  always_comb begin
    half_bit = tick && (tcnt == 4'd7);
    full_bit = tick && (tcnt == 4'd15);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      sync1         <= 1'b1;
      rx_s          <= 1'b1;
      rx_prev       <= 1'b1;
      acc           <= '0;
      tcnt          <= '0;
      bcnt          <= '0;
      shreg         <= '0;
      data          <= '0;
      data_valid    <= 1'b0;
      FTDI_RTS      <= 1'b1;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      sync1         <= FTDI_TX;
      rx_s          <= sync1;
      rx_prev       <= rx_s;
      framing_error <= 1'b0;

      if (state == IDLE)
        acc <= '0;
      else
        acc <= {1'b0, acc[W-1:0]} + INC;

      if (tick)
        tcnt <= tcnt + 4'd1;

      // Ack handled first so a coincident stop-bit load below takes priority.
      if (data_valid && data_ack) begin
        data_valid <= 1'b0;
        overrun    <= 1'b0;
        FTDI_RTS   <= 1'b1;
      end

      case (state)
        IDLE: begin
          tcnt <= '0;
          if (!rx_s && rx_prev)
            state <= START;
        end
        START: begin
          if (half_bit) begin
            if (!rx_s) begin
              state <= DATA;
              tcnt  <= '0;
              bcnt  <= '0;
            end else begin
              state <= IDLE;
            end
          end
        end
        DATA: begin
          if (full_bit) begin
            shreg <= {rx_s, shreg[7:1]};
            bcnt  <= bcnt + 3'd1;
            if (bcnt == 3'd7)
              state <= STOP;
          end
        end
        STOP: begin
          if (full_bit) begin
            state <= IDLE;
            if (rx_s) begin
              data       <= shreg;
              data_valid <= 1'b1;
              FTDI_RTS   <= 1'b0;
              if (data_valid && !data_ack)
                overrun <= 1'b1;
            end else begin
              framing_error <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ftdi_receiver.sv
// Bench for ftdi_receiver: directed frames plus random frames, checked against
// a byte-level model of the holding register (data/valid/overrun/framing).
module tb_ftdi_receiver;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       FTDI_TX = 1'b1;
  logic       FTDI_RTS;
  logic [7:0] data;
  logic       data_valid;
  logic       data_ack = 1'b0;
  logic       framing_error;
  logic       overrun;
  logic [1:0] state_test;

  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned cyc = 0;
  int unsigned start_cyc = 0;
  int unsigned rise_cyc = 0;
  int unsigned fe_total = 0;
  int unsigned fe_run = 0;
  int unsigned fe_max_run = 0;
  int unsigned dv_rises = 0;
  logic        dv_prev = 1'b0;

  logic [7:0] exp_data;
  logic       exp_dv;
  logic       exp_ovr;

  ftdi_receiver #(.FREQUENCY(16), .BAUD_RATE(1)) dut (
    .clk          (clk),
    .reset        (reset),
    .FTDI_TX      (FTDI_TX),
    .FTDI_RTS     (FTDI_RTS),
    .data         (data),
    .data_valid   (data_valid),
    .data_ack     (data_ack),
    .framing_error(framing_error),
    .overrun      (overrun),
    .state_test   (state_test)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (framing_error) begin
      fe_total = fe_total + 1;
      fe_run   = fe_run + 1;
      if (fe_run > fe_max_run) fe_max_run = fe_run;
    end else begin
      fe_run = 0;
    end
    if (data_valid && !dv_prev) begin
      rise_cyc = cyc;
      dv_rises = dv_rises + 1;
    end
    dv_prev = data_valid;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      failures = failures + 1;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One 8N1 frame at 16 clk/bit, followed by a short idle-high gap.
  task automatic send_frame(input logic [7:0] b, input logic stop_ok);
    start_cyc = cyc;
    FTDI_TX = 1'b0;
    wait_clk(16);
    for (int i = 0; i < 8; i++) begin
      FTDI_TX = b[i];
      wait_clk(16);
    end
    FTDI_TX = stop_ok;
    wait_clk(16);
    FTDI_TX = 1'b1;
    wait_clk(4);
    if (stop_ok) begin
      if (exp_dv) exp_ovr = 1'b1;
      exp_data = b;
      exp_dv   = 1'b1;
    end
  endtask

  task automatic ack_once();
    data_ack = 1'b1;
    wait_clk(1);
    data_ack = 1'b0;
    exp_dv  = 1'b0;
    exp_ovr = 1'b0;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".data"}, 32'(data), 32'(exp_data));
    check({tag, ".valid"}, 32'(data_valid), 32'(exp_dv));
    check({tag, ".rts"}, 32'(FTDI_RTS), 32'(!exp_dv));
    check({tag, ".ovr"}, 32'(overrun), 32'(exp_ovr));
  endtask

  initial begin
    int unsigned fe_before;
    int unsigned rises_before;
    logic [7:0]  rb;
    logic        rstop;

    exp_data = '0;
    exp_dv   = 1'b0;
    exp_ovr  = 1'b0;

    reset = 1'b0;
    wait_clk(4);
    reset = 1'b1;
    wait_clk(2);
    check_model("reset");
    check("reset.fe", 32'(framing_error), 32'd0);
    check("reset.state", 32'(state_test), 32'd0);

    // 1: basic frame and latency
    fe_before = fe_total;
    send_frame(8'hA5, 1'b1);
    check_model("t1");
    check("t1.fe", fe_total - fe_before, 32'd0);
    check("t1.lat_lo", 32'(rise_cyc - start_cyc >= 153), 32'd1);
    check("t1.lat_hi", 32'(rise_cyc - start_cyc <= 157), 32'd1);

    // 2: ack
    ack_once();
    check_model("t2");
    check("t2.data", 32'(data), 32'hA5);

    // 3: glitch, then a good frame
    fe_before    = fe_total;
    rises_before = dv_rises;
    FTDI_TX = 1'b0;
    wait_clk(4);
    FTDI_TX = 1'b1;
    wait_clk(30);
    check("t3.state", 32'(state_test), 32'd0);
    check("t3.norise", dv_rises - rises_before, 32'd0);
    check("t3.nofe", fe_total - fe_before, 32'd0);
    send_frame(8'h3C, 1'b1);
    check_model("t3");
    ack_once();

    // 4: bad stop bit
    fe_before = fe_total;
    fe_max_run = 0;
    send_frame(8'hFF, 1'b0);
    wait_clk(10);
    check("t4.fe_count", fe_total - fe_before, 32'd1);
    check("t4.fe_width", fe_max_run, 32'd1);
    check("t4.valid", 32'(data_valid), 32'd0);
    check("t4.state", 32'(state_test), 32'd0);

    // 5: overrun
    send_frame(8'h01, 1'b1);
    send_frame(8'h02, 1'b1);
    check_model("t5");
    check("t5.ovr_set", 32'(overrun), 32'd1);
    ack_once();
    check_model("t5ack");

    // 6: reset mid-DATA
    send_frame(8'h99, 1'b1);
    rises_before = dv_rises;
    FTDI_TX = 1'b0; wait_clk(16);
    FTDI_TX = 1'b1; wait_clk(16);
    FTDI_TX = 1'b0; wait_clk(16);
    FTDI_TX = 1'b1; wait_clk(2);
    check("t6.in_data", 32'(state_test), 32'd2);
    wait_clk(6);
    reset = 1'b0;
    wait_clk(1);
    reset = 1'b1;
    exp_data = '0;
    exp_dv   = 1'b0;
    exp_ovr  = 1'b0;
    check_model("t6rst");
    check("t6.state", 32'(state_test), 32'd0);
    check("t6.fe", 32'(framing_error), 32'd0);
    wait_clk(200);
    check("t6.norise", dv_rises - rises_before, 32'd0);
    send_frame(8'hC3, 1'b1);
    check_model("t6");

    // Random frames against the model
    for (int n = 0; n < 16; n++) begin
      if (exp_dv && ($urandom % 2 == 0)) ack_once();
      rb    = 8'($urandom);
      rstop = ($urandom % 4) != 0;
      fe_before = fe_total;
      send_frame(rb, rstop);
      check_model("rnd");
      check("rnd.fe", fe_total - fe_before, rstop ? 32'd0 : 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
